// File: rtl/y86_regfile_wb.sv
// Y-86 SEQ decode / write-back: register ID decode, fifteen 64-bit program
// registers with two write ports (E and M), and the sticky processor status.
module y86_regfile_wb #(
    parameter logic [63:0] STACK_INIT = 64'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  icode,
    input  logic [3:0]  rA,
    input  logic [3:0]  rB,
    input  logic        cnd,
    input  logic [63:0] valE,
    input  logic [63:0] valM,
    input  logic        wb_en,
    output logic [63:0] valA,
    output logic [63:0] valB,
    output logic [3:0]  srcA,
    output logic [3:0]  srcB,
    output logic [3:0]  dstE,
    output logic [3:0]  dstM,
    output logic [2:0]  stat,
    input  logic [3:0]  dbg_sel,
    output logic [63:0] dbg_val
);

    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] RSP      = 4'h4;
    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_INS = 3'd4;

    logic [2:0]        r_stat;
    logic              w_commit;
    logic [15:0][63:0] w_rd;

    always_comb begin
        srcA = RNONE;
        srcB = RNONE;
        dstE = RNONE;
        dstM = RNONE;
        case (icode)
            4'd2: begin
                srcA = rA;
                dstE = cnd ? rB : RNONE;
            end
            4'd3: dstE = rB;
            4'd4: begin
                srcA = rA;
                srcB = rB;
            end
            4'd5: begin
                srcB = rB;
                dstM = rA;
            end
            4'd6: begin
                srcA = rA;
                srcB = rB;
                dstE = rB;
            end
            4'd8: begin
                srcB = RSP;
                dstE = RSP;
            end
            4'd9: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
            end
            4'd10: begin
                srcA = rA;
                srcB = RSP;
                dstE = RSP;
            end
            4'd11: begin
                srcA = RSP;
                srcB = RSP;
                dstE = RSP;
                dstM = rA;
            end
            default: ;
        endcase
    end

    // Halt and invalid codes commit a status change only, never a register write.
    assign w_commit = wb_en && (r_stat == STAT_AOK) && (icode != 4'd0) && (icode <= 4'd11);

    generate
        for (genvar gi = 0; gi < 15; gi++) begin : g_reg
            logic [63:0] r_reg;
            // M port wins when both ports target the same register (popq %rsp).
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_reg <= (gi == 4) ? STACK_INIT : 64'd0;
                end else if (w_commit && (dstM == 4'(gi))) begin
                    r_reg <= valM;
                end else if (w_commit && (dstE == 4'(gi))) begin
                    r_reg <= valE;
                end
            end
            assign w_rd[gi] = r_reg;
        end
    endgenerate

    assign w_rd[15] = 64'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat <= STAT_AOK;
        end else if (wb_en && (r_stat == STAT_AOK)) begin
            if (icode == 4'd0) begin
                r_stat <= STAT_HLT;
            end else if (icode > 4'd11) begin
                r_stat <= STAT_INS;
            end
        end
    end

    assign valA    = w_rd[srcA];
    assign valB    = w_rd[srcB];
    assign dbg_val = w_rd[dbg_sel];
    assign stat    = r_stat;

endmodule

// File: tb/tb_y86_regfile_wb.sv
// Randomised bench for y86_regfile_wb against an architectural register-file model.
module tb_y86_regfile_wb;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [3:0]  icode = '0, rA = '0, rB = '0, dbg_sel = '0;
    logic        cnd = 1'b0, wb_en = 1'b0;
    logic [63:0] valE = '0, valM = '0;
    logic [63:0] valA, valB, dbg_val;
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [2:0]  stat;

    y86_regfile_wb #(.STACK_INIT(64'h100)) dut (
        .clk(clk), .rst(rst), .icode(icode), .rA(rA), .rB(rB), .cnd(cnd),
        .valE(valE), .valM(valM), .wb_en(wb_en), .valA(valA), .valB(valB),
        .srcA(srcA), .srcB(srcB), .dstE(dstE), .dstM(dstM), .stat(stat),
        .dbg_sel(dbg_sel), .dbg_val(dbg_val)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [63:0] m_reg [0:15];
    int          m_stat;
    logic [63:0] last_valA, last_valB;
    logic [3:0]  last_srcA, last_srcB, last_dstE;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural decode straight from the instruction tables.
    task automatic ref_dec(input int ic, input int a, input int b, input bit c,
                           output int sA, output int sB, output int dE, output int dM);
        sA = (ic inside {2, 4, 6, 10}) ? a : (ic inside {9, 11}) ? 4 : 15;
        sB = (ic inside {4, 5, 6}) ? b : (ic inside {[8:11]}) ? 4 : 15;
        dE = (ic inside {3, 6}) ? b : (ic == 2) ? (c ? b : 15) : (ic inside {[8:11]}) ? 4 : 15;
        dM = (ic inside {5, 11}) ? a : 15;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = 64'd0;
        m_reg[4] = 64'h100;
        m_stat   = 1;
    endtask

    // One instruction: drive at negedge, check decode/reads, commit at posedge, check state.
    task automatic step(input int ic, input int a, input int b, input bit c,
                        input logic [63:0] e, input logic [63:0] m, input bit en, input int sel);
        int sA, sB, dE, dM;
        @(negedge clk);
        icode = 4'(ic); rA = 4'(a); rB = 4'(b); cnd = c;
        valE = e; valM = m; wb_en = en; dbg_sel = 4'(sel);
        ref_dec(ic, a, b, c, sA, sB, dE, dM);
        #1;
        check("srcA", 64'(srcA), 64'(sA));
        check("srcB", 64'(srcB), 64'(sB));
        check("dstE", 64'(dstE), 64'(dE));
        check("dstM", 64'(dstM), 64'(dM));
        check("valA", valA, m_reg[sA]);
        check("valB", valB, m_reg[sB]);
        last_valA = valA; last_valB = valB;
        last_srcA = srcA; last_srcB = srcB; last_dstE = dstE;
        @(posedge clk);
        if (en && m_stat == 1) begin
            if (ic == 0) m_stat = 2;
            else if (ic > 11) m_stat = 4;
            else begin
                if (dE != 15) m_reg[dE] = e;
                if (dM != 15) m_reg[dM] = m;
            end
        end
        #1;
        check("stat", 64'(stat), 64'(m_stat));
        check("dbg_val", dbg_val, m_reg[sel]);
        $display("txn icode=%0d rA=%0d rB=%0d cnd=%0b wb=%0b valE=%h valM=%h sel=%0d dbg=%h stat=%0d",
                 ic, a, b, c, en, e, m, sel, dbg_val, stat);
    endtask

    // Asynchronous reset mid-cycle, with a write pending that must be discarded.
    task automatic do_reset();
        @(negedge clk);
        icode = 4'd3; rB = 4'd2; valE = 64'hDEAD; wb_en = 1'b1;
        #2 rst = 1'b1;
        #1;
        model_reset();
        check("rst_stat", 64'(stat), 64'd1);
        for (int s = 0; s < 16; s++) begin
            dbg_sel = 4'(s);
            #1 check("rst_dbg", dbg_val, m_reg[s]);
        end
        @(negedge clk);
        wb_en = 1'b0;
        rst   = 1'b0;
        $display("txn reset stat=%0d", stat);
    endtask

    initial begin
        model_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        do_reset();

        step(3, 15, 2, 0, 64'hABCD, 64'h0, 1, 2);
        check("irmov_r2", dbg_val, 64'hABCD);
        step(6, 2, 2, 0, 64'h0, 64'h0, 0, 2);
        check("opq_valA", last_valA, 64'hABCD);
        check("opq_valB", last_valB, 64'hABCD);
        step(2, 1, 3, 0, 64'd5, 64'h0, 1, 3);
        check("cmov0_dstE", 64'(last_dstE), 64'hF);
        check("cmov0_r3", dbg_val, 64'd0);
        step(2, 1, 3, 1, 64'd5, 64'h0, 1, 3);
        check("cmov1_r3", dbg_val, 64'd5);
        step(11, 4, 15, 0, 64'h108, 64'h55, 1, 4);
        check("pop_srcA", 64'(last_srcA), 64'd4);
        check("pop_srcB", 64'(last_srcB), 64'd4);
        check("pop_rsp", dbg_val, 64'h55);
        step(0, 15, 15, 0, 64'h0, 64'h0, 1, 1);
        check("halt_stat", 64'(stat), 64'd2);
        step(3, 15, 1, 0, 64'd7, 64'h0, 1, 1);
        check("halt_r1", dbg_val, 64'd0);
        check("halt_sticky", 64'(stat), 64'd2);
        do_reset();
        check("after_rst_stat", 64'(stat), 64'd1);
        step(3, 15, 2, 0, 64'hABCD, 64'h0, 1, 2);
        step(12, 2, 2, 0, 64'h77, 64'h88, 1, 2);
        check("ins_stat", 64'(stat), 64'd4);
        check("ins_r2", dbg_val, 64'hABCD);
        do_reset();

        for (int t = 0; t < 400; t++) begin
            int ic;
            if (m_stat != 1 && $urandom_range(0, 3) == 0) do_reset();
            if ($urandom_range(0, 99) < 4)
                ic = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(12, 15);
            else
                ic = $urandom_range(1, 11);
            step(ic, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 ($urandom_range(0, 4) != 0), $urandom_range(0, 15));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/y86_regfile_wb.md
# y86_regfile_wb

Decode/write-back block for the Y-86 SEQ datapath. It decodes `icode`/`rA`/`rB` into register source and destination IDs and supplies `valA`/`valB` to the execute stage. At the end of each instruction cycle it writes `valE` and `valM` back into the fifteen 64-bit program registers, with `cnd` gating conditional moves. It also holds the sticky processor status, which blocks architectural writes after `halt` or an invalid instruction.

## Interface
Parameters:
- `STACK_INIT`, default `64'd0`: reset value of `%rsp` (register 4).

Ports:
- `clk`, in, 1: the single clock; all state updates on its rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `icode`, in, 4: current instruction code.
- `rA`, in, 4: register A field.
- `rB`, in, 4: register B field.
- `cnd`, in, 1: condition result from execute; used only for `icode`=2.
- `valE`, in, 64: execute result.
- `valM`, in, 64: memory read data.
- `wb_en`, in, 1: commit strobe; write-back and status update occur at the edge where it is high.
- `valA`, out, 64: operand A.
- `valB`, out, 64: operand B.
- `srcA`, out, 4: decoded source register ID.
- `srcB`, out, 4: decoded source register ID.
- `dstE`, out, 4: decoded destination register ID.
- `dstM`, out, 4: decoded destination register ID.
- `stat`, out, 3: status. 1=AOK, 2=HLT, 4=INS.
- `dbg_sel`, in, 4: debug register select.
- `dbg_val`, out, 64: debug read data.

## Operation
- Register ID 15 (`F`) means "none": it reads as 0 and writes to it are dropped. ID 4 is `%rsp`.
- `srcA`:
  - `rA` for `icode` 2, 4, 6, 10.
  - 4 for `icode` 9, 11.
  - Otherwise `F`.
- `srcB`:
  - `rB` for `icode` 4, 5, 6.
  - 4 for `icode` 8, 9, 10, 11.
  - Otherwise `F`.
- `dstE`:
  - `rB` for `icode` 3 and 6.
  - `rB` for `icode` 2 when `cnd`=1; `F` when `cnd`=0.
  - 4 for `icode` 8, 9, 10, 11.
  - Otherwise `F`.
- `dstM`: `rA` for `icode` 5 and 11; otherwise `F`.
- `valA` = `R[srcA]` and `valB` = `R[srcB]`, combinational. Each is 0 when its ID is `F`.
- `dbg_val` = `R[dbg_sel]`, combinational; 0 when `dbg_sel`=15.
- Write-back happens at the rising edge when `wb_en`=1 and `stat`=AOK:
  - `R[dstE]` <= `valE`, and `R[dstM]` <= `valM`.
  - If `dstE`=`dstM` and neither is `F`, only `valM` is written. Example: `popq %rsp` leaves `%rsp` equal to the popped value.
- Status register (sticky):
  - Resets to AOK.
  - At an edge with `wb_en`=1 and `stat`=AOK: `icode`=0 sets HLT; `icode` > 11 sets INS; otherwise it stays AOK.
  - An instruction that sets HLT or INS performs no register write.
  - Once HLT or INS, no register or status change occurs until `rst`.
- Decode outputs are pure functions of the inputs and do not depend on `stat`.

## Timing
- Reset (asynchronous, immediate):
  - All registers go to 0, except R4, which goes to `STACK_INIT`.
  - `stat` goes to 1.
  - While `rst`=1, `valA`, `valB` and `dbg_val` reflect the reset contents.
- Read-during-write: combinational reads in the same cycle as a write return the pre-edge value (no bypass). New values are visible immediately after the edge.
- Write latency is one edge from `wb_en`.
- `wb_en`=0 for any number of cycles changes no state.
- Reset asserted mid-instruction overrides any pending write in that cycle.
- No arithmetic is performed. All data paths are full 64-bit and passed unmodified.

## Test plan
- **Reset:** pulse `rst` asynchronously between edges with `STACK_INIT`=`64'h100` → immediately R4=`0x100`, `dbg_val` for registers 0..14 except 4 reads 0, and `stat`=1.
- **irmovq / OPq:**
  - `icode`=3, `rB`=2, `valE`=`0xABCD`, `wb_en`=1 → `dbg_sel`=2 reads `0xABCD` after the edge.
  - Then `icode`=6, `rA`=2, `rB`=2 → `valA`=`valB`=`0xABCD`.
- **cmovXX:** `icode`=2, `rA`=1, `rB`=3, `valE`=5:
  - `cnd`=0 → `dstE`=`F` and R3 is unchanged.
  - `cnd`=1 → R3=5 after the edge.
- **popq %rsp:** `icode`=11, `rA`=4, `valE`=`0x108`, `valM`=`0x55` → R4=`0x55`. Same cycle `srcA`=`srcB`=4.
- **Halt sticky:**
  - `icode`=0 with `wb_en` → `stat`=2.
  - Then `icode`=3, `rB`=1, `valE`=7 → R1 unchanged and `stat` stays 2 until `rst`, after which it is 1.
- **Invalid instruction:** `icode`=12 with `wb_en` → `stat`=4. A same-cycle read of any register returns its old value, with no write.
